vga_timing_gen: RTL

- Generates the VGA raster for the video pipeline: it drives the H/V counters, the sync signals and blanking that the pixel-processing stages consume.
- Issues pixel read requests with addresses to the upstream frame source, early enough to cover its read latency.
- Registers the returned RGB onto the DAC outputs, forced to zero outside the active window.

---
 rtl/vga_timing_gen.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster generator: H/V counters, syncs, blanking, early pixel requests
// to the frame source and registered RGB for the DAC.
module vga_timing_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACT    = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACT    = 480,
  parameter int V_FRONT  = 10,
  parameter int REQ_LEAD = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        ENABLE,
  input  logic [7:0]  R_IN,
  input  logic [7:0]  G_IN,
  input  logic [7:0]  B_IN,
  output logic        DATA_REQ,
  output logic [9:0]  X_ADDR,
  output logic [9:0]  Y_ADDR,
  output logic [12:0] VGA_H_CNT,
  output logic [12:0] VGA_V_CNT,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK,
  output logic [7:0]  R_OUT,
  output logic [7:0]  G_OUT,
  output logic [7:0]  B_OUT,
  output logic        FRAME_DONE
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACT + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACT + V_FRONT;

  localparam logic [12:0] H_LAST_C  = 13'(H_TOTAL - 1);
  localparam logic [12:0] V_LAST_C  = 13'(V_TOTAL - 1);
  localparam logic [12:0] H_SYNC_C  = 13'(H_SYNC);
  localparam logic [12:0] V_SYNC_C  = 13'(V_SYNC);
  localparam logic [12:0] X_START_C = 13'(H_SYNC + H_BACK);
  localparam logic [12:0] X_END_C   = 13'(H_SYNC + H_BACK + H_ACT);
  localparam logic [12:0] Y_START_C = 13'(V_SYNC + V_BACK);
  localparam logic [12:0] Y_END_C   = 13'(V_SYNC + V_BACK + V_ACT);
  localparam logic [12:0] LEAD_C    = 13'(REQ_LEAD);

  logic [12:0] h_cnt_q, h_cnt_d;
  logic [12:0] v_cnt_q, v_cnt_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        blank_q, blank_d;
  logic        req_q, req_d;
  logic [9:0]  x_addr_q, x_addr_d;
  logic [9:0]  y_addr_q, y_addr_d;
  logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
  logic        frame_done_q, frame_done_d;

  logic        h_wrap, v_wrap;
  logic [12:0] h_lead;
  logic        h_act_nxt, v_act_nxt, req_h_nxt;

  assign h_wrap = (h_cnt_q == H_LAST_C);
  assign v_wrap = (v_cnt_q == V_LAST_C);

  // Counters sit at (0,0) while idle, so the first running clock shows (1,0).
  assign h_cnt_d = !ENABLE ? '0 : (h_wrap ? '0 : h_cnt_q + 13'd1);
  assign v_cnt_d = !ENABLE ? '0 :
                   (h_wrap ? (v_wrap ? '0 : v_cnt_q + 13'd1) : v_cnt_q);

  // Every output is decoded from the next counter value so it lines up with
  // the counters displayed in the same cycle.
  assign h_lead    = h_cnt_d + LEAD_C;
  assign h_act_nxt = (h_cnt_d >= X_START_C) && (h_cnt_d < X_END_C);
  assign v_act_nxt = (v_cnt_d >= Y_START_C) && (v_cnt_d < Y_END_C);
  assign req_h_nxt = (h_lead >= X_START_C) && (h_lead < X_END_C);

  always_comb begin
    hs_d         = 1'b1;
    vs_d         = 1'b1;
    blank_d      = 1'b0;
    req_d        = 1'b0;
    x_addr_d     = '0;
    y_addr_d     = '0;
    r_d          = '0;
    g_d          = '0;
    b_d          = '0;
    frame_done_d = 1'b0;
    if (ENABLE) begin
      hs_d         = !(h_cnt_d < H_SYNC_C);
      vs_d         = !(v_cnt_d < V_SYNC_C);
      blank_d      = h_act_nxt && v_act_nxt;
      req_d        = req_h_nxt && v_act_nxt;
      x_addr_d     = x_addr_q;
      y_addr_d     = y_addr_q;
      if (req_d) begin
        x_addr_d = 10'(h_lead - X_START_C);
        y_addr_d = 10'(v_cnt_d - Y_START_C);
      end
      if (blank_d) begin
        r_d = R_IN;
        g_d = G_IN;
        b_d = B_IN;
      end
      frame_done_d = h_wrap && v_wrap;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      hs_q         <= 1'b1;
      vs_q         <= 1'b1;
      blank_q      <= 1'b0;
      req_q        <= 1'b0;
      x_addr_q     <= '0;
      y_addr_q     <= '0;
      r_q          <= '0;
      g_q          <= '0;
      b_q          <= '0;
      frame_done_q <= 1'b0;
    end else begin
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      blank_q      <= blank_d;
      req_q        <= req_d;
      x_addr_q     <= x_addr_d;
      y_addr_q     <= y_addr_d;
      r_q          <= r_d;
      g_q          <= g_d;
      b_q          <= b_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign VGA_H_CNT  = h_cnt_q;
  assign VGA_V_CNT  = v_cnt_q;
  assign VGA_HS     = hs_q;
  assign VGA_VS     = vs_q;
  assign VGA_BLANK  = blank_q;
  assign DATA_REQ   = req_q;
  assign X_ADDR     = x_addr_q;
  assign Y_ADDR     = y_addr_q;
  assign R_OUT      = r_q;
  assign G_OUT      = g_q;
  assign B_OUT      = b_q;
  assign FRAME_DONE = frame_done_q;

endmodule
